// File: rtl/rs232_defs.sv
// Shared RS232 definitions: FSM state encoding and baud/clock constants.
// The future TX unit imports the same package.
package rs232_defs;

  localparam int CLK_HZ           = 50_000_000;
  localparam int BAUD             = 115_200;
  localparam int CLKS_PER_BIT_DEF = CLK_HZ / BAUD;  // 434

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_e;

  // Start-edge to start-bit mid-sample distance.
  function automatic int half_bit(input int cpb);
    return cpb / 2;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous inputs (serial lines, buttons).
// RST_VAL sets the level both stages take in reset.
module sync_2ff #(
  parameter int   W       = 1,
  parameter logic RST_VAL = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [1:0][W-1:0] ff;

  always_ff @(posedge clk) begin
    if (rst) ff <= {(2*W){RST_VAL}};
    else     ff <= {ff[0], d};
  end

  assign q = ff[1];

endmodule

// File: rtl/rs232_rx_unit.sv
// 8N1 serial receiver: synchronised rx line, mid-bit sampling, one-cycle
// rxrdy / frame_err strobes, and a BREAK state that swallows a held-low line.
module rs232_rx_unit
  import rs232_defs::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int HALF_BIT     = half_bit(CLKS_PER_BIT)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rxdw,
  output logic       rxrdy,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int            CW      = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_TC = CW'(HALF_BIT - 1);
  localparam logic [CW-1:0] BIT_TC  = CW'(CLKS_PER_BIT - 1);

  logic          rx_s;
  rx_state_e     state, state_nxt;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  logic half_tc, bit_tc;
  logic counting, cnt_clr, sample_en, rdy_set, ferr_set;

  sync_2ff #(.W(1), .RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  assign half_tc = (cnt == HALF_TC);
  assign bit_tc  = (cnt == BIT_TC);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (!rx_s)  state_nxt = START;
      START:   if (half_tc) state_nxt = rx_s ? IDLE : DATA;
      DATA:    if (bit_tc && bit_idx == 3'd7) state_nxt = STOP;
      STOP:    if (bit_tc) state_nxt = rx_s ? IDLE : BREAK;
      BREAK:   if (rx_s)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    rx_busy   = (state != IDLE);
    counting  = (state == START) || (state == DATA) || (state == STOP);
    sample_en = (state == DATA) && bit_tc;
    rdy_set   = (state == STOP) && bit_tc &&  rx_s;
    ferr_set  = (state == STOP) && bit_tc && !rx_s;
    // Counter restarts on every state entry and at each data-bit boundary.
    cnt_clr   = (state_nxt != state) || sample_en || !counting;
  end

  // Datapath: baud counter, bit index, shift register, strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      rxdw      <= '0;
      rxrdy     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      cnt <= cnt_clr ? '0 : cnt + 1'b1;

      if (state == START)  bit_idx <= '0;
      else if (sample_en)  bit_idx <= bit_idx + 1'b1;

      if (sample_en) shreg <= {rx_s, shreg[7:1]};

      if (rdy_set) rxdw <= shreg;
      rxrdy     <= rdy_set;
      frame_err <= ferr_set;
    end
  end

endmodule

// File: tb/tb_rs232_rx_unit.sv
// Bench for rs232_rx_unit at CLKS_PER_BIT=16: vector table, hand-written
// corner sequences and skewed random frames checked against a byte queue.
`timescale 1ps/1ps
module tb_rs232_rx_unit;

  localparam int CPB    = 16;
  localparam int HALF   = 5000;          // ps, half clock period
  localparam int BIT_PS = CPB * 2 * HALF;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] rxdw;
  logic       rxrdy, frame_err, rx_busy;

  rs232_rx_unit #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rxdw      (rxdw),
    .rxrdy     (rxrdy),
    .frame_err (frame_err),
    .rx_busy   (rx_busy)
  );

  always #(HALF) clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int fall_cyc = 0;
  int rdy_cyc  = 0;
  int ferr_cnt = 0;
  int viol     = 0;
  logic prev_rdy = 1'b0;
  logic [7:0] got_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rxrdy) begin
      if (prev_rdy) viol = viol + 1;
      got_q.push_back(rxdw);
      rdy_cyc = cyc;
    end
    if (rxrdy && frame_err) viol = viol + 1;
    if (frame_err) ferr_cnt = ferr_cnt + 1;
    prev_rdy = rxrdy;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
  endtask

  task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
    n_checks++;
    if (act >= lo && act <= hi) n_pass++;
    else $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int bit_ps);
    fall_cyc = cyc;
    rx = 1'b0;
    #(bit_ps);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      #(bit_ps);
    end
    rx = stop;
    #(bit_ps);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_rdy;
    int         exp_ferr;
    logic [7:0] exp_rxdw;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int b_rdy, b_ferr, base;
    logic [7:0] exp_q[$];

    vecs[0] = '{8'h55, 1'b1, 1, 0, 8'h55};
    vecs[1] = '{8'hA3, 1'b1, 1, 0, 8'hA3};
    vecs[2] = '{8'h00, 1'b1, 1, 0, 8'h00};
    vecs[3] = '{8'hFF, 1'b1, 1, 0, 8'hFF};
    vecs[4] = '{8'h11, 1'b1, 1, 0, 8'h11};
    vecs[5] = '{8'h3C, 1'b0, 0, 1, 8'h11};

    // Reset state
    idle(3);
    chk("reset_rxdw", rxdw, 0);
    chk("reset_rxrdy", rxrdy, 0);
    chk("reset_frame_err", frame_err, 0);
    chk("reset_rx_busy", rx_busy, 0);
    rst = 1'b0;
    idle(5);

    // 0x55 with latency measurement
    b_rdy = got_q.size();
    send_frame(8'h55, 1'b1, BIT_PS);
    idle(20);
    chk("h55_count", got_q.size() - b_rdy, 1);
    if (got_q.size() > b_rdy) chk("h55_data", got_q[b_rdy], 8'h55);
    chk_rng("h55_latency", rdy_cyc - fall_cyc, 2 + CPB/2 + 9*CPB, 2 + CPB/2 + 9*CPB + 2);
    chk("h55_ferr", ferr_cnt, 0);

    // Start-bit glitch
    b_rdy = got_q.size();
    rx = 1'b0;
    idle(3);
    rx = 1'b1;
    idle(30);
    chk("glitch_no_rdy", got_q.size() - b_rdy, 0);
    chk("glitch_no_ferr", ferr_cnt, 0);
    chk("glitch_rxdw", rxdw, 8'h55);
    chk("glitch_idle", rx_busy, 0);

    // Back-to-back frames, one stop bit
    b_rdy = got_q.size();
    send_frame(8'hA3, 1'b1, BIT_PS);
    send_frame(8'h0F, 1'b1, BIT_PS);
    idle(20);
    chk("b2b_count", got_q.size() - b_rdy, 2);
    if (got_q.size() >= b_rdy + 2) begin
      chk("b2b_first", got_q[b_rdy], 8'hA3);
      chk("b2b_second", got_q[b_rdy+1], 8'h0F);
    end
    chk("b2b_rxdw", rxdw, 8'h0F);

    // Vector table
    for (int v = 0; v < 6; v++) begin
      b_rdy  = got_q.size();
      b_ferr = ferr_cnt;
      send_frame(vecs[v].data, vecs[v].stop, BIT_PS);
      if (!vecs[v].stop) begin
        idle(100);
        chk($sformatf("vec%0d_break_busy", v), rx_busy, 1);
        rx = 1'b1;
      end
      idle(20);
      chk($sformatf("vec%0d_rdy", v), got_q.size() - b_rdy, vecs[v].exp_rdy);
      chk($sformatf("vec%0d_ferr", v), ferr_cnt - b_ferr, vecs[v].exp_ferr);
      chk($sformatf("vec%0d_rxdw", v), rxdw, vecs[v].exp_rxdw);
      chk($sformatf("vec%0d_idle", v), rx_busy, 0);
    end

    // Reset in the middle of data bit 4
    b_rdy = got_q.size();
    @(negedge clk);
    fork
      send_frame(8'hFF, 1'b1, BIT_PS);
      begin
        idle(2 + CPB/2 + 4*CPB + 8);
        chk("rst_mid_busy_before", rx_busy, 1);
        rst = 1'b1;
        idle(1);
        chk("rst_mid_rxdw", rxdw, 0);
        chk("rst_mid_rxrdy", rxrdy, 0);
        chk("rst_mid_busy", rx_busy, 0);
        rst = 1'b0;
      end
    join
    idle(20);
    chk("rst_mid_no_rdy", got_q.size() - b_rdy, 0);
    send_frame(8'h81, 1'b1, BIT_PS);
    idle(20);
    chk("post_rst_count", got_q.size() - b_rdy, 1);
    chk("post_rst_rxdw", rxdw, 8'h81);

    // Random bytes with +-2% baud skew and random gaps
    base   = got_q.size();
    b_ferr = ferr_cnt;
    for (int i = 0; i < 24; i++) begin
      logic [7:0] d;
      int bp;
      d  = 8'($urandom_range(0, 255));
      bp = BIT_PS - BIT_PS/50 + int'($urandom_range(0, 2*(BIT_PS/50)));
      exp_q.push_back(d);
      send_frame(d, 1'b1, bp);
      #($urandom_range(0, 2*BIT_PS));
    end
    idle(40);
    chk("rand_count", got_q.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (base + i < got_q.size())
        chk($sformatf("rand_byte%0d", i), got_q[base+i], exp_q[i]);
    chk("rand_no_ferr", ferr_cnt - b_ferr, 0);

    chk("strobe_rules", viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
